sbqm_queue_counter: RTL and testbench

//  Occupancy and wait-time stage of the bank SBqM system, directly downstream of
//  the sensor flip-flops. Takes the registered entry/exit photocell levels, edge-detects

---
 rtl/sbqm_queue_counter.sv | 114 +++++++++++
 tb/tb_sbqm_queue_counter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/sbqm_queue_counter.sv
// sbqm_queue_counter
// Occupancy and wait-time stage of the bank queue system. Edge-detects the
// synchronised entry/exit photocells and keeps a saturating customer count.
// It then derives an estimated waiting time from that count and the number of
// active tellers.
// Optional feature macro: SBQM_ERR_EN enables the sticky over/underflow flag
// 'err' (cleared by err_clr). When the macro is undefined, err is tied to 0.
module sbqm_queue_counter #(
  parameter int CNT_W = 3,
  parameter int SVC_T = 3,
  parameter int WT_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             front_sens,
  input  logic             back_sens,
  input  logic [1:0]       tcount,
  input  logic             err_clr,
  output logic [CNT_W-1:0] pcount,
  output logic             full,
  output logic             empty,
  output logic [WT_W-1:0]  wtime,
  output logic             err
);

  localparam logic [CNT_W-1:0] PMAX = '1;
  localparam logic [WT_W-1:0]  SVC  = WT_W'(SVC_T);

  logic            front_d;
  logic            back_d;
  logic            arr;
  logic            dep;
  logic [WT_W-1:0] num;
  logic [WT_W-1:0] wtime_nxt;

  // Previous sensor levels. They reset high, so a sensor that is already
  // blocked when reset is released must fall and rise again to count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      front_d <= 1'b1;
      back_d  <= 1'b1;
    end else begin
      front_d <= front_sens;
      back_d  <= back_sens;
    end
  end

  assign arr   = front_sens & ~front_d;
  assign dep   = back_sens & ~back_d;
  assign full  = (pcount == PMAX);
  assign empty = (pcount == '0);

  // Saturating up/down occupancy count. Simultaneous arrival and departure
  // cancel out. Requests that would wrap past full or empty are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcount <= '0;
    end else if (arr && !dep && !full) begin
      pcount <= pcount + 1'b1;
    end else if (dep && !arr && !empty) begin
      pcount <= pcount - 1'b1;
    end
  end

  // Wait estimate: SVC_T*(pcount+tcount-1)/tcount. The divisor is only ever
  // 1, 2 or 3, so each case uses a constant divide instead of a generic divider.
  always_comb begin
    num       = SVC * (WT_W'(pcount) + WT_W'(tcount) - WT_W'(1));
    wtime_nxt = '0;
    if (pcount == '0) begin
      wtime_nxt = '0;
    end else begin
      case (tcount)
        2'd1:    wtime_nxt = num;
        2'd2:    wtime_nxt = num >> 1;
        2'd3:    wtime_nxt = num / WT_W'(3);
        default: wtime_nxt = '1;
      endcase
    end
  end

  // Registered wait time, one cycle behind the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wtime <= '0;
    end else begin
      wtime <= wtime_nxt;
    end
  end

`ifdef SBQM_ERR_EN
  logic err_set;

  assign err_set = (arr & ~dep & full) | (dep & ~arr & empty);

  // Sticky error flag. A new over/underflow takes priority over a clear that
  // arrives in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (err_set) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end
`else
  logic unused_err_clr;

  assign unused_err_clr = err_clr;
  assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_sbqm_queue_counter.sv
// tb_sbqm_queue_counter
// Directed bench for sbqm_queue_counter at default parameters
// (CNT_W=3, SVC_T=3, WT_W=5). The expected err value follows SBQM_ERR_EN.
module tb_sbqm_queue_counter;

  logic       clk;
  logic       rst;
  logic       front_sens;
  logic       back_sens;
  logic [1:0] tcount;
  logic       err_clr;
  logic [2:0] pcount;
  logic       full;
  logic       empty;
  logic [4:0] wtime;
  logic       err;

  int checks;
  int errors;

`ifdef SBQM_ERR_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  sbqm_queue_counter dut (
    .clk       (clk),
    .rst       (rst),
    .front_sens(front_sens),
    .back_sens (back_sens),
    .tcount    (tcount),
    .err_clr   (err_clr),
    .pcount    (pcount),
    .full      (full),
    .empty     (empty),
    .wtime     (wtime),
    .err       (err)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge and settle 1 ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Raise the sensors for one sampled cycle, then drop them. On return the
  // count has taken the event, but wtime has not yet.
  task automatic applyStimulus(input logic f, input logic b);
    front_sens = f;
    back_sens  = b;
    step();
    front_sens = 1'b0;
    back_sens  = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    front_sens = 1'b1;
    back_sens  = 1'b0;
    tcount     = 2'd2;
    err_clr    = 1'b0;

    // T1: reset with front held high
    step();
    step();
    checkOutput("rst_pcount", int'(pcount), 0);
    checkOutput("rst_empty", int'(empty), 1);
    checkOutput("rst_full", int'(full), 0);
    checkOutput("rst_wtime", int'(wtime), 0);
    checkOutput("rst_err", int'(err), 0);
    rst = 1'b0;
    step();
    step();
    step();
    checkOutput("t1_held_pcount", int'(pcount), 0);
    front_sens = 1'b0;
    step();
    checkOutput("t1_low_pcount", int'(pcount), 0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("t1_rise_pcount", int'(pcount), 1);

    // Mid-operation reset clears immediately
    rst = 1'b1;
    #1;
    checkOutput("midrst_pcount", int'(pcount), 0);
    step();
    rst = 1'b0;
    step();
    $display("[TB] T2 arrivals with tcount=2");

    // T2: three arrivals with two tellers
    applyStimulus(1'b1, 1'b0);
    checkOutput("t2_p1", int'(pcount), 1);
    checkOutput("t2_w_lag1", int'(wtime), 0);
    step();
    checkOutput("t2_w1", int'(wtime), 3);
    applyStimulus(1'b1, 1'b0);
    checkOutput("t2_p2", int'(pcount), 2);
    step();
    checkOutput("t2_w2", int'(wtime), 4);
    applyStimulus(1'b1, 1'b0);
    checkOutput("t2_p3", int'(pcount), 3);
    checkOutput("t2_w_lag3", int'(wtime), 4);
    step();
    checkOutput("t2_w3", int'(wtime), 6);

    // T3: five more arrivals (eight in total) saturate at 7
    for (int i = 4; i <= 8; i++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput("t3_pcount", int'(pcount), (i > 7) ? 7 : i);
      step();
    end
    checkOutput("t3_full", int'(full), 1);
    checkOutput("t3_empty", int'(empty), 0);
    checkOutput("t3_wtime", int'(wtime), 12);
    checkOutput("t3_err_set", int'(err), int'(ERR_ON));
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    checkOutput("t3_err_clr", int'(err), 0);

    // T5 at full: simultaneous edges leave the count alone
    applyStimulus(1'b1, 1'b1);
    checkOutput("t5_full_pcount", int'(pcount), 7);
    step();
    checkOutput("t5_full_err", int'(err), 0);

    // T4: drain 7 -> 0
    for (int i = 6; i >= 0; i--) begin
      applyStimulus(1'b0, 1'b1);
      checkOutput("t4_pcount", int'(pcount), i);
      step();
    end
    checkOutput("t4_empty", int'(empty), 1);
    checkOutput("t4_wtime", int'(wtime), 0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("t4_under_pcount", int'(pcount), 0);
    step();
    checkOutput("t4_under_err", int'(err), int'(ERR_ON));
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    checkOutput("t4_err_clr", int'(err), 0);

    // T5 at empty
    applyStimulus(1'b1, 1'b1);
    checkOutput("t5_empty_pcount", int'(pcount), 0);
    step();
    checkOutput("t5_empty_err", int'(err), 0);

    // T5 at 4
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 1'b0);
      step();
    end
    checkOutput("t5_fill4", int'(pcount), 4);
    checkOutput("t5_w4", int'(wtime), 7);
    applyStimulus(1'b1, 1'b1);
    checkOutput("t5_mid_pcount", int'(pcount), 4);
    step();

    // T6: tcount sweep at pcount=5
    applyStimulus(1'b1, 1'b0);
    step();
    checkOutput("t6_p5", int'(pcount), 5);
    tcount = 2'd1;
    checkOutput("t6_lag", int'(wtime), 9);
    step();
    checkOutput("t6_tc1", int'(wtime), 15);
    tcount = 2'd2;
    step();
    checkOutput("t6_tc2", int'(wtime), 9);
    tcount = 2'd3;
    step();
    checkOutput("t6_tc3", int'(wtime), 7);
    tcount = 2'd0;
    step();
    checkOutput("t6_tc0", int'(wtime), 31);

    // Final reset clears everything at once
    rst = 1'b1;
    #1;
    checkOutput("end_rst_pcount", int'(pcount), 0);
    checkOutput("end_rst_wtime", int'(wtime), 0);
    checkOutput("end_rst_empty", int'(empty), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
